// File: rtl/epl_row_access_seq_pkg.sv
// Shared definitions for the EPLFFRAM02 row access sequencer: array geometry,
// 3-bit phase encodings and default phase lengths.
`ifndef EPLFFRAM02_SPEC_VH
`define EPLFFRAM02_SPEC_VH
`define ADDR_AX 3
`define ADDR_AC 2
`endif

package epl_row_access_seq_pkg;

    localparam int DEF_ROW_W     = `ADDR_AX;
    localparam int DEF_COL_W     = `ADDR_AC;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_PLATE   = 3;
    localparam int DEF_T_SENSE   = 2;
    localparam int DEF_T_RESTORE = 3;
    localparam int DEF_T_PRE     = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PLATE   = 3'd2,
        ST_SENSE   = 3'd3,
        ST_RESTORE = 3'd4,
        ST_PRE     = 3'd5
    } state_t;

    // A zero-length phase would never finish, so it is treated as one cycle.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/epl_phase_timer.sv
// Loadable 4-bit phase down-counter; done is high during the last cycle of
// the loaded phase.
module epl_phase_timer
    import epl_row_access_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= clamp_len(load_val);
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd1);

endmodule

// File: rtl/epl_row_access_seq.sv
// Access sequencer for the EPLFFRAM02 array: latches one request, then steps
// the word-line, plate, sense-amp and bit-line-driver enables through fixed phases.
module epl_row_access_seq
    import epl_row_access_seq_pkg::*;
#(
    parameter int ROW_W     = DEF_ROW_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_PLATE   = DEF_T_PLATE,
    parameter int T_SENSE   = DEF_T_SENSE,
    parameter int T_RESTORE = DEF_T_RESTORE,
    parameter int T_PRE     = DEF_T_PRE
) (
    input  logic                   pClk_i,
    input  logic                   pRstn_i,
    input  logic                   pReq_i,
    input  logic                   pWe_i,
    input  logic [ROW_W+COL_W-1:0] pAddr_i,
    input  logic [DATA_W-1:0]      pWdata_i,
    output logic                   pReady_o,
    output logic [ROW_W-1:0]       pAr_o,
    output logic [COL_W-1:0]       pAc_o,
    output logic                   pWlEn_o,
    output logic                   pPlEn_o,
    output logic                   pSaEn_o,
    output logic                   pWdrvEn_o,
    output logic [DATA_W-1:0]      pBlData_o,
    input  logic [DATA_W-1:0]      pSaData_i,
    output logic [DATA_W-1:0]      pRdata_o,
    output logic                   pRvalid_o
);

    localparam logic [3:0] LEN_SETUP   = 4'(T_SETUP);
    localparam logic [3:0] LEN_PLATE   = 4'(T_PLATE);
    localparam logic [3:0] LEN_SENSE   = 4'(T_SENSE);
    localparam logic [3:0] LEN_RESTORE = 4'(T_RESTORE);
    localparam logic [3:0] LEN_PRE     = 4'(T_PRE);

    state_t     state;
    state_t     next_state;
    logic       is_write;
    logic       we_next;
    logic       accept;
    logic       capture;
    logic       load;
    logic [3:0] load_val;
    logic       done;

    logic              ready_q;
    logic [ROW_W-1:0]  ar_q;
    logic [COL_W-1:0]  ac_q;
    logic              wl_q;
    logic              pl_q;
    logic              sa_q;
    logic              wdrv_q;
    logic [DATA_W-1:0] bl_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    epl_phase_timer u_timer (
        .clk      (pClk_i),
        .rst_n    (pRstn_i),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge pClk_i or negedge pRstn_i) begin
        if (!pRstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each phase loads the timer for the following phase as it exits.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = 4'd0;
        accept     = 1'b0;
        capture    = 1'b0;
        we_next    = is_write;
        unique case (state)
            ST_IDLE: begin
                if (pReq_i) begin
                    accept     = 1'b1;
                    we_next    = pWe_i;
                    next_state = ST_SETUP;
                    load       = 1'b1;
                    load_val   = LEN_SETUP;
                end
            end
            ST_SETUP: begin
                if (done) begin
                    next_state = ST_PLATE;
                    load       = 1'b1;
                    load_val   = LEN_PLATE;
                end
            end
            ST_PLATE: begin
                if (done) begin
                    load = 1'b1;
                    if (is_write) begin
                        next_state = ST_RESTORE;
                        load_val   = LEN_RESTORE;
                    end else begin
                        next_state = ST_SENSE;
                        load_val   = LEN_SENSE;
                    end
                end
            end
            ST_SENSE: begin
                if (done) begin
                    capture    = 1'b1;
                    next_state = ST_RESTORE;
                    load       = 1'b1;
                    load_val   = LEN_RESTORE;
                end
            end
            ST_RESTORE: begin
                if (done) begin
                    next_state = ST_PRE;
                    load       = 1'b1;
                    load_val   = LEN_PRE;
                end
            end
            ST_PRE: begin
                if (done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Enables are decoded from the next state so they line up with the phase.
    always_ff @(posedge pClk_i or negedge pRstn_i) begin
        if (!pRstn_i) begin
            ready_q  <= 1'b1;
            is_write <= 1'b0;
            ar_q     <= '0;
            ac_q     <= '0;
            wl_q     <= 1'b0;
            pl_q     <= 1'b0;
            sa_q     <= 1'b0;
            wdrv_q   <= 1'b0;
            bl_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ready_q  <= (next_state == ST_IDLE);
            wl_q     <= (next_state == ST_SETUP) || (next_state == ST_PLATE) ||
                        (next_state == ST_SENSE) || (next_state == ST_RESTORE);
            pl_q     <= (next_state == ST_PLATE);
            sa_q     <= !we_next && ((next_state == ST_PLATE) || (next_state == ST_SENSE));
            wdrv_q   <= (next_state == ST_RESTORE) || (we_next && (next_state == ST_PLATE));
            rvalid_q <= capture;
            if (accept) begin
                is_write <= pWe_i;
                ar_q     <= pAddr_i[ROW_W+COL_W-1:COL_W];
                ac_q     <= pAddr_i[COL_W-1:0];
                bl_q     <= pWdata_i;
            end
            if (capture) begin
                rdata_q <= pSaData_i;
                bl_q    <= pSaData_i;
            end
        end
    end

    assign pReady_o  = ready_q;
    assign pAr_o     = ar_q;
    assign pAc_o     = ac_q;
    assign pWlEn_o   = wl_q;
    assign pPlEn_o   = pl_q;
    assign pSaEn_o   = sa_q;
    assign pWdrvEn_o = wdrv_q;
    assign pBlData_o = bl_q;
    assign pRdata_o  = rdata_q;
    assign pRvalid_o = rvalid_q;

endmodule

// File: tb/tb_epl_row_access_seq.sv
// Self-checking bench for epl_row_access_seq: a default-timed instance and an
// all-zero-timed (clamped to 1) instance driven from a shared vector table.
module tb_epl_row_access_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req, we, sel;
    logic [4:0] addr;
    logic [7:0] wdata, sa;

    logic       d_req, f_req;
    logic       d_ready, d_wl, d_pl, d_saen, d_wdrv, d_rvalid;
    logic [2:0] d_ar;
    logic [1:0] d_ac;
    logic [7:0] d_bl, d_rdata;
    logic       f_ready, f_wl, f_pl, f_saen, f_wdrv, f_rvalid;
    logic [2:0] f_ar;
    logic [1:0] f_ac;
    logic [7:0] f_bl, f_rdata;

    logic       obs_ready, obs_wl, obs_pl, obs_saen, obs_wdrv, obs_rvalid;
    logic [2:0] obs_ar;
    logic [1:0] obs_ac;
    logic [7:0] obs_bl, obs_rdata;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_rd[2] = '{8'h00, 8'h00};

    typedef struct {
        logic       sel;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        int busy, wl, pl, saen, wdrv, rvalid, pl_off, rv_edge, cap_cyc, poke_cyc;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    assign d_req = req & ~sel;
    assign f_req = req & sel;

    assign obs_ready  = sel ? f_ready  : d_ready;
    assign obs_wl     = sel ? f_wl     : d_wl;
    assign obs_pl     = sel ? f_pl     : d_pl;
    assign obs_saen   = sel ? f_saen   : d_saen;
    assign obs_wdrv   = sel ? f_wdrv   : d_wdrv;
    assign obs_rvalid = sel ? f_rvalid : d_rvalid;
    assign obs_ar     = sel ? f_ar     : d_ar;
    assign obs_ac     = sel ? f_ac     : d_ac;
    assign obs_bl     = sel ? f_bl     : d_bl;
    assign obs_rdata  = sel ? f_rdata  : d_rdata;

    epl_row_access_seq dut (
        .pClk_i(clk), .pRstn_i(rst_n), .pReq_i(d_req), .pWe_i(we), .pAddr_i(addr),
        .pWdata_i(wdata), .pReady_o(d_ready), .pAr_o(d_ar), .pAc_o(d_ac),
        .pWlEn_o(d_wl), .pPlEn_o(d_pl), .pSaEn_o(d_saen), .pWdrvEn_o(d_wdrv),
        .pBlData_o(d_bl), .pSaData_i(sa), .pRdata_o(d_rdata), .pRvalid_o(d_rvalid)
    );

    epl_row_access_seq #(
        .T_SETUP(0), .T_PLATE(0), .T_SENSE(0), .T_RESTORE(0), .T_PRE(0)
    ) dut_fast (
        .pClk_i(clk), .pRstn_i(rst_n), .pReq_i(f_req), .pWe_i(we), .pAddr_i(addr),
        .pWdata_i(wdata), .pReady_o(f_ready), .pAr_o(f_ar), .pAc_o(f_ac),
        .pWlEn_o(f_wl), .pPlEn_o(f_pl), .pSaEn_o(f_saen), .pWdrvEn_o(f_wdrv),
        .pBlData_o(f_bl), .pSaData_i(sa), .pRdata_o(f_rdata), .pRvalid_o(f_rvalid)
    );

    function automatic vec_t mk(input logic s, input logic w, input logic [2:0] row,
                                input logic [1:0] col, input logic [7:0] d, input int poke);
        vec_t v;
        v.sel = s; v.we = w; v.addr = {row, col}; v.data = d; v.poke_cyc = poke;
        if (!s) begin
            v.pl = 3; v.pl_off = 2;
            if (!w) begin
                v.busy = 12; v.wl = 10; v.saen = 5; v.wdrv = 3; v.rvalid = 1; v.rv_edge = 7; v.cap_cyc = 7;
            end else begin
                v.busy = 10; v.wl = 8; v.saen = 0; v.wdrv = 6; v.rvalid = 0; v.rv_edge = -1; v.cap_cyc = 0;
            end
        end else begin
            v.pl = 1; v.pl_off = 1;
            if (!w) begin
                v.busy = 5; v.wl = 4; v.saen = 2; v.wdrv = 1; v.rvalid = 1; v.rv_edge = 3; v.cap_cyc = 3;
            end else begin
                v.busy = 4; v.wl = 3; v.saen = 0; v.wdrv = 2; v.rvalid = 0; v.rv_edge = -1; v.cap_cyc = 0;
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transaction from a negedge and leaves the bench on a negedge.
    task automatic applyStimulus(input vec_t v);
        int busy = -1;
        int nwl = 0, npl = 0, nsa = 0, nwd = 0, nrv = 0;
        int wl_first = -1, pl_first = -1, rv_edge = -1;
        int ar_bad = 0, idle_bad = 0;
        logic [7:0] bl_rest = 8'h00;
        sel   = v.sel;
        we    = v.we;
        addr  = v.addr;
        wdata = v.we ? v.data : ~v.data;
        sa    = ~v.data;
        req   = 1'b1;
        if (!v.we) sb_q.push_back(v.data);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (obs_ar !== v.addr[4:2] || obs_ac !== v.addr[1:0]) ar_bad++;
            if (obs_ready) begin
                busy = cyc - 1;
                break;
            end
            if (obs_wl) begin nwl++; if (wl_first < 0) wl_first = cyc - 1; end
            if (obs_pl) begin npl++; if (pl_first < 0) pl_first = cyc - 1; end
            if (obs_saen) nsa++;
            if (obs_wdrv) nwd++;
            if (obs_wdrv && !obs_pl) bl_rest = obs_bl;
            if (obs_rvalid) begin
                nrv++;
                if (rv_edge < 0) rv_edge = cyc - 1;
                if (sb_q.size() == 0) checkOutput("rvalid_unexpected", 1, 0);
                else checkOutput("rdata_scoreboard", {24'h0, obs_rdata}, {24'h0, sb_q.pop_front()});
            end
            req = (cyc == v.poke_cyc);
            if (cyc == v.poke_cyc) begin
                we   = 1'b1;
                addr = {3'd2, 2'd0};
            end
            if (!v.we) sa = (cyc == v.cap_cyc) ? v.data : ~v.data;
        end
        req = 1'b0;
        if (busy < 0) checkOutput("ready_timeout", 0, 1);
        checkOutput("sb_leftover", sb_q.size(), 0);
        sb_q.delete();
        checkOutput("busy_cycles", busy, v.busy);
        checkOutput("wl_cycles", nwl, v.wl);
        checkOutput("pl_cycles", npl, v.pl);
        checkOutput("sa_cycles", nsa, v.saen);
        checkOutput("wdrv_cycles", nwd, v.wdrv);
        checkOutput("rvalid_pulses", nrv, v.rvalid);
        checkOutput("pl_after_wl", pl_first - wl_first, v.pl_off);
        checkOutput("addr_unstable", ar_bad, 0);
        checkOutput("bl_in_restore", {24'h0, bl_rest}, {24'h0, v.data});
        if (!v.we) begin
            checkOutput("rvalid_edge", rv_edge, v.rv_edge);
            last_rd[v.sel] = v.data;
        end
        checkOutput("rdata_hold", {24'h0, obs_rdata}, {24'h0, last_rd[v.sel]});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!obs_ready || obs_wl) idle_bad++;
        end
        checkOutput("idle_after_done", idle_bad, 0);
    endtask

    initial begin
        req = 1'b0; we = 1'b0; sel = 1'b0; addr = 5'd0; wdata = 8'h00; sa = 8'h00;

        // Asynchronous reset, asserted well before the first rising edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_ready", obs_ready, 1);
        checkOutput("reset_enables", {obs_wl, obs_pl, obs_saen, obs_wdrv, obs_rvalid}, 0);
        checkOutput("reset_addr", {obs_ar, obs_ac}, 0);
        checkOutput("reset_bl", obs_bl, 0);
        checkOutput("reset_rdata", obs_rdata, 0);
        checkOutput("reset_fast_ready", f_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = mk(1'b0, 1'b0, 3'd5, 2'd1, 8'hA5, 0);
        vecs[1] = mk(1'b0, 1'b1, 3'd7, 2'd2, 8'h3C, 0);
        vecs[2] = mk(1'b0, 1'b0, 3'd0, 2'd3, 8'h5A, 0);
        vecs[3] = mk(1'b0, 1'b1, 3'd2, 2'd0, 8'hC3, 0);
        vecs[4] = mk(1'b0, 1'b0, 3'd5, 2'd1, 8'h11, 6);
        vecs[5] = mk(1'b1, 1'b0, 3'd4, 2'd1, 8'h96, 0);
        for (int r = 0; r < 8; r++) begin
            vecs[6 + r] = mk(1'b1, r[0], 3'(r), 2'(r + 1), 8'(r * 37 + 9), 0);
        end

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // Reset in the middle of a read's plate phase.
        sel = 1'b0; we = 1'b0; addr = {3'd3, 2'd2}; wdata = 8'h00; sa = 8'h77; req = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            req = 1'b0;
        end
        checkOutput("pl_before_reset", obs_pl, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_enables", {obs_wl, obs_pl, obs_saen, obs_wdrv, obs_rvalid}, 0);
        checkOutput("abort_ready", obs_ready, 1);
        begin
            int rv_seen = 0;
            int not_ready = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (obs_rvalid) rv_seen++;
            end
            rst_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (obs_rvalid) rv_seen++;
                if (!obs_ready) not_ready++;
            end
            checkOutput("abort_no_rvalid", rv_seen, 0);
            checkOutput("abort_stays_idle", not_ready, 0);
        end
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        checkOutput("abort_rdata_cleared", obs_rdata, 0);
        checkOutput("abort_ar_cleared", obs_ar, 0);
        applyStimulus(mk(1'b0, 1'b0, 3'd3, 2'd2, 8'h77, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/epl_row_access_seq.md
Name: epl_row_access_seq

Overview:
Access sequencer for the EPLFFRAM02 array. It accepts one read or write request at a time and registers the row address that drives the row decoder's pAr_i input. It then times the word-line, plate, sense-amp and bit-line-driver enables through a fixed phase sequence. Reads are destructive, so every read restores the sensed data before the array is released.

Parameters:
ROW_W, `ADDR_AX (3), row address width; feeds the row decoder.
COL_W, `ADDR_AC (2), column address width.
DATA_W, 8, data width.
T_SETUP, 2, cycles word line is on before the plate pulse.
T_PLATE, 3, plate-pulse cycles.
T_SENSE, 2, sense-amp settle cycles; read only.
T_RESTORE, 3, restore/write-1 cycles with the plate low.
T_PRE, 2, precharge cycles with all enables off.
All T_* parameters have a legal range of 1..15; a value of 0 behaves as 1.

Ports:
pClk_i  in  1  clock
pRstn_i  in  1  async active-low reset
pReq_i  in  1  request; accepted when pReq_i=1 and pReady_o=1
pWe_i  in  1  1=write, 0=read; sampled at accept
pAddr_i  in  ROW_W+COL_W  {row,col}; sampled at accept
pWdata_i  in  DATA_W  write data; sampled at accept
pReady_o  out  1  sequencer idle
pAr_o  out  ROW_W  registered row address to the row decoder
pAc_o  out  COL_W  registered column address
pWlEn_o  out  1  word-line enable (gates the decoded line)
pPlEn_o  out  1  plate-line enable
pSaEn_o  out  1  sense-amp enable
pWdrvEn_o  out  1  bit-line driver enable
pBlData_o  out  DATA_W  bit-line drive data
pSaData_i  in  DATA_W  sense-amp output
pRdata_o  out  DATA_W  read data
pRvalid_o  out  1  one-cycle read-data strobe

Behaviour:
- Reset (asynchronous, pRstn_i=0): state IDLE. pReady_o=1. Every other output is 0, including pAr_o, pAc_o, pBlData_o and pRdata_o. A reset mid-operation aborts the operation immediately, and the read data of an aborted read is lost.
- FSM states: IDLE, SETUP, PLATE, SENSE, RESTORE, PRE. Each timed state lasts exactly its T_* cycles, counted by a 4-bit down-counter loaded on entry.
- IDLE: pReady_o=1.
  - On accept, latch the address into pAr_o/pAc_o, latch pWe_i, and latch pWdata_i into pBlData_o.
  - Next state is SETUP.
- Read path: SETUP -> PLATE -> SENSE -> RESTORE -> PRE -> IDLE.
- Write path: SETUP -> PLATE -> RESTORE -> PRE -> IDLE; SENSE is skipped.
- pWlEn_o: 1 in SETUP, PLATE, SENSE and RESTORE.
- pPlEn_o: 1 in PLATE only.
- pSaEn_o: 1 in PLATE and SENSE on reads; 0 on writes.
- pWdrvEn_o: 1 in PLATE and RESTORE on writes; 1 in RESTORE only on reads.
- Sense capture: on the last SENSE cycle, pSaData_i is captured into both pRdata_o and pBlData_o. Restore therefore writes back the sensed data.
- pRvalid_o is high for exactly the first RESTORE cycle. pRdata_o holds its value until the next read capture.
- pAr_o and pAc_o stay stable from the cycle after accept until the next accept, and hold their value in IDLE.
- All outputs are registered; there are no combinational paths from input to output.
- pReady_o is 0 from the cycle after accept through the last PRE cycle.
- Latency with default parameters:
  - Read: busy for 12 cycles; pRvalid_o rises 7 cycles after the accept edge.
  - Write: busy for 10 cycles.
- Back-to-back requests are separated by at least one IDLE cycle.
- pReq_i while busy is ignored and never queued; the requester must hold the request until accepted.
- pSaData_i is a don't-care outside the capture cycle.

Decomposition:
- EPLFFRAM02_spec.vh holds `ADDR_AX, `ADDR_AC, the DATA_W default, the state encodings (3-bit) and the default T_* values.
- Sub-module epl_phase_timer: a loadable 4-bit down-counter with a 0->1 clamp and a done pulse. It is instantiated once.
- The top level contains the FSM and the output registers.

Test Plan:
1. Reset: assert pRstn_i mid-cycle -> all outputs 0 asynchronously and pReady_o=1.
2. Read, defaults: addr={3'd5,2'd1} and pSaData_i=8'hA5 -> pAr_o=5 and pWlEn_o asserted for 10 cycles. pPlEn_o high for 3 cycles, starting 2 cycles after pWlEn_o rises. pRvalid_o is a single pulse with pRdata_o=8'hA5. During RESTORE, pBlData_o=8'hA5 with pWdrvEn_o=1. pReady_o returns after 12 cycles.
3. Write, defaults: addr row 7, pWdata_i=8'h3C -> pBlData_o=8'h3C. pWdrvEn_o is high in PLATE and RESTORE (6 cycles), pSaEn_o never rises, pRvalid_o never pulses, busy for 10 cycles.
4. Request while busy: pulse pReq_i (write, row 2) during a read's SENSE phase -> ignored; pAr_o is unchanged and no second sequence runs.
5. Reset mid-read: deassert pRstn_i during PLATE -> enables drop the same cycle, no pRvalid_o, and after release pReady_o=1 and a new read completes normally.
6. All T_* set to 0 (clamped to 1) -> read busy for 5 cycles and write busy for 4; row sweep 0..7 gives pAr_o matching each address.
